// File: rtl/if_stage_if.sv
// Signal bundle between the instruction-fetch stage, the instruction memory,
// the hazard/redirect logic and the decode stage.
interface if_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_valid;
   logic [31:0] fetch_count;

   // Fetch stage side: owns the memory address and the IF/ID register.
   modport master (
      input  stall, redirect, redirect_pc, im_data,
      output im_addr, id_instr, id_pc, id_pc_plus4, id_valid, fetch_count
   );

   // Environment side: hazard unit, branch resolution, memory and decode.
   modport slave (
      output stall, redirect, redirect_pc, im_data,
      input  im_addr, id_instr, id_pc, id_pc_plus4, id_valid, fetch_count
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register. Priority per edge: reset > redirect > stall > advance.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input logic      clk,
   input logic      rst,
   if_stage_if.master bus
);

   localparam int DATA_W = 32;

   logic [DATA_W-1:0] pc_p0;
   logic [DATA_W-1:0] instr_p1;
   logic [DATA_W-1:0] pc_p1;
   logic [DATA_W-1:0] pc_plus4_p1;
   logic              vld_p1;
   logic [DATA_W-1:0] fetch_cnt;

   // Modulo-2^32 word step; wraps 0xFFFF_FFFC to 0.
   function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] a);
      return a + 32'd4;
   endfunction

   // Redirect targets are forced word-aligned; misaligned low bits are dropped.
   function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] a);
      return {a[DATA_W-1:2], 2'b00};
   endfunction

   // ---- stage p0: program counter ----
   // Program counter update.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p0 <= RESET_PC;
      end else if (bus.redirect) begin
         pc_p0 <= align_word(bus.redirect_pc);
      end else if (!bus.stall) begin
         pc_p0 <= next_word(pc_p0);
      end
   end

   // ---- stage p1: IF/ID register ----
   // IF/ID capture: bubble on redirect, hold on stall, latch fetched word otherwise.
   always_ff @(posedge clk) begin
      if (rst || bus.redirect) begin
         instr_p1    <= NOP_INSTR;
         pc_p1       <= '0;
         pc_plus4_p1 <= '0;
         vld_p1      <= 1'b0;
      end else if (!bus.stall) begin
         instr_p1    <= bus.im_data;
         pc_p1       <= pc_p0;
         pc_plus4_p1 <= next_word(pc_p0);
         vld_p1      <= 1'b1;
      end
   end

   // Count of real instructions entering IF/ID; wraps modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
      end else if (!bus.redirect && !bus.stall) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

   assign bus.im_addr     = pc_p0;
   assign bus.id_instr    = instr_p1;
   assign bus.id_pc       = pc_p1;
   assign bus.id_pc_plus4 = pc_plus4_p1;
   assign bus.id_valid    = vld_p1;
   assign bus.fetch_count = fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a reference model pushes the expected
// post-edge state into a scoreboard queue as each cycle's stimulus is driven;
// the entry is popped and compared against the DUT after the edge.
module tb_if_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic        vld;
      logic [31:0] fc;
   } snap_t;

   logic clk = 1'b0;
   logic rst;
   int   compared = 0;
   int   mismatched = 0;

   logic [31:0] mem [0:127];
   snap_t       m;
   snap_t       q [$];

   if_stage_if bus ();

   if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory, word address im_addr[8:2].
   assign bus.im_data = mem[bus.im_addr[8:2]];

   function automatic snap_t snap();
      snap_t s;
      s.pc    = bus.im_addr;
      s.instr = bus.id_instr;
      s.ipc   = bus.id_pc;
      s.ipc4  = bus.id_pc_plus4;
      s.vld   = bus.id_valid;
      s.fc    = bus.fetch_count;
      return s;
   endfunction

   // Drive one cycle of stimulus, push the model's expected state, clock it.
   task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      if (r) begin
         m = '{pc: RESET_PC, instr: NOP_INSTR, ipc: 32'h0, ipc4: 32'h0, vld: 1'b0, fc: 32'h0};
      end else if (rd) begin
         m.pc = {rpc[31:2], 2'b00};
         m.instr = NOP_INSTR; m.ipc = 32'h0; m.ipc4 = 32'h0; m.vld = 1'b0;
      end else if (!s) begin
         m.instr = mem[m.pc[8:2]];
         m.ipc   = m.pc;
         m.ipc4  = m.pc + 32'd4;
         m.vld   = 1'b1;
         m.pc    = m.pc + 32'd4;
         m.fc    = m.fc + 32'd1;
      end
      q.push_back(m);
      rst = r; bus.stall = s; bus.redirect = rd; bus.redirect_pc = rpc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      snap_t e, o;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0044);
      for (int i = 0; i < 2; i++) begin
         e = q.pop_front();
         if (i == 1) begin
            o = snap(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL reset_state got %h want %h", o, e); end
         end
      end
      compared++;
      if ({bus.id_valid, bus.id_instr, bus.fetch_count, bus.im_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
         mismatched++;
         $display("FAIL reset_const got vld=%b instr=%h fc=%h pc=%h want 0/0/0/0",
                  bus.id_valid, bus.id_instr, bus.fetch_count, bus.im_addr);
      end
   endtask

   task automatic test_advance();
      snap_t e, o;
      logic [31:0] instr_seq [4];
      instr_seq = '{32'h2008_0001, 32'h2009_0002, 32'h0109_5020, 32'h0000_0000};
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (bus.im_addr !== 32'(i * 4)) begin
            mismatched++; $display("FAIL adv_im_addr[%0d] got %h want %h", i, bus.im_addr, 32'(i * 4));
         end
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         e = q.pop_front(); o = snap(); compared++;
         if (o !== e) begin mismatched++; $display("FAIL adv[%0d] got %h want %h", i, o, e); end
         compared++;
         if (bus.id_instr !== instr_seq[i] || bus.id_pc_plus4 !== bus.id_pc + 32'd4) begin
            mismatched++;
            $display("FAIL adv_instr[%0d] got %h/%h/%h want %h/pc+4", i, bus.id_instr, bus.id_pc, bus.id_pc_plus4, instr_seq[i]);
         end
      end
      compared++;
      if (bus.fetch_count !== 32'd4) begin
         mismatched++; $display("FAIL adv_count got %0d want 4", bus.fetch_count);
      end
   endtask

   task automatic test_stall_redirect();
      snap_t e, o;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      void'(q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      void'(q.pop_front()); void'(q.pop_front());
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0);
         e = q.pop_front(); o = snap(); compared++;
         if (o !== e) begin mismatched++; $display("FAIL stall[%0d] got %h want %h", i, o, e); end
         compared++;
         if ({bus.im_addr, bus.id_instr, bus.id_pc, bus.id_valid, bus.fetch_count} !==
             {32'h8, 32'h2009_0002, 32'h4, 1'b1, 32'd2}) begin
            mismatched++;
            $display("FAIL stall_hold[%0d] got pc=%h instr=%h ipc=%h vld=%b fc=%0d want 8/20090002/4/1/2",
                     i, bus.im_addr, bus.id_instr, bus.id_pc, bus.id_valid, bus.fetch_count);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      e = q.pop_front(); compared++;
      if (bus.id_pc !== 32'h8 || snap() !== e) begin
         mismatched++; $display("FAIL stall_release got %h want %h", snap(), e);
      end
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.im_addr !== 32'h40 || bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0) begin
         mismatched++; $display("FAIL redirect_bubble got %h want %h", snap(), e);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.id_pc !== 32'h40 || bus.id_instr !== mem[16] || bus.id_valid !== 1'b1) begin
         mismatched++; $display("FAIL redirect_target got %h want %h", snap(), e);
      end
   endtask

   task automatic test_redirect_with_stall();
      snap_t e;
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0023);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.im_addr !== 32'h20 || bus.id_valid !== 1'b0) begin
         mismatched++; $display("FAIL redir_stall got %h want %h", snap(), e);
      end
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0031);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.im_addr !== 32'h30 || bus.id_valid !== 1'b0) begin
         mismatched++; $display("FAIL redir_consec got %h want %h", snap(), e);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.id_pc !== 32'h30 || bus.id_valid !== 1'b1) begin
         mismatched++; $display("FAIL redir_resume got %h want %h", snap(), e);
      end
   endtask

   task automatic test_wrap();
      snap_t e;
      drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      void'(q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc_plus4 !== 32'h0 ||
          bus.im_addr !== 32'h0 || bus.id_instr !== mem[127]) begin
         mismatched++; $display("FAIL wrap got %h want %h", snap(), e);
      end
   endtask

   task automatic test_reset_in_stall();
      snap_t e;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      void'(q.pop_front());
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         void'(q.pop_front());
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.fetch_count !== 32'd7) begin
         mismatched++; $display("FAIL pre_reset got %h want %h", snap(), e);
      end
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.im_addr !== RESET_PC || bus.id_valid !== 1'b0 || bus.fetch_count !== 32'd0) begin
         mismatched++; $display("FAIL reset_in_stall got %h want %h", snap(), e);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      e = q.pop_front(); compared++;
      if (snap() !== e || bus.id_pc !== 32'h0 || bus.id_instr !== mem[0] || bus.fetch_count !== 32'd1) begin
         mismatched++; $display("FAIL resume_after_reset got %h want %h", snap(), e);
      end
   endtask

   task automatic test_back_to_back();
      snap_t e, o;
      logic r, s, rd;
      logic [31:0] rpc;
      for (int i = 0; i < 200; i++) begin
         r   = ($urandom_range(0, 39) == 0);
         s   = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         rpc = $urandom();
         drive(r, s, rd, rpc);
         e = q.pop_front(); o = snap(); compared++;
         if (o !== e) begin mismatched++; $display("FAIL random[%0d] got %h want %h", i, o, e); end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h8C00_0000 + 32'(i * 32'h0001_0103);
      mem[0] = 32'h2008_0001;
      mem[1] = 32'h2009_0002;
      mem[2] = 32'h0109_5020;
      mem[3] = 32'h0000_0000;
      rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
      m = '0;
      #1;
      test_reset();
      test_advance();
      test_stall_redirect();
      test_redirect_with_stall();
      test_wrap();
      test_reset_in_stall();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
